// File: rtl/mux_rr_arb_pkg.sv
// mux_pkg: shared mode encodings and the round-robin pick used by mux_rr_arb.
package mux_pkg;

    localparam logic MODE_RR  = 1'b0;
    localparam logic MODE_SEL = 1'b1;
    localparam int   MAX_CH   = 16;

    // First set bit of req searching ptr, ptr+1, ... with wrap at n; one-hot result.
    function automatic logic [MAX_CH-1:0] rr_pick(input logic [MAX_CH-1:0] req, input int ptr, input int n);
        logic [MAX_CH-1:0] g;
        int idx;
        g = '0;
        for (int k = MAX_CH - 1; k >= 0; k--) begin
            if (k < n) begin
                idx = ptr + k;
                if (idx >= n) idx = idx - n;
                if (req[idx]) g = MAX_CH'(1) << idx;
            end
        end
        return g;
    endfunction

endpackage

// File: rtl/mux_rr_arb_arbiter.sv
// rr_arbiter: combinational round-robin grant from req and the rotating pointer.
module rr_arbiter
    import mux_pkg::*;
#(
    parameter  int N_CH  = 4,
    localparam int SEL_W = $clog2(N_CH)
) (
    input  logic [N_CH-1:0]  req_i,
    input  logic [SEL_W-1:0] ptr_i,
    output logic [N_CH-1:0]  grant_o
);

    assign grant_o = N_CH'(rr_pick(MAX_CH'(req_i), int'(ptr_i), N_CH));

endmodule

// File: rtl/mux_rr_arb.sv
// mux_rr_arb: N-channel registered mux with round-robin or explicit select and valid/ready on all sides.
// Define MUX_RR_ARB_LOCK_EN to add in_last and hold the grant on one channel until a packet's last beat.
module mux_rr_arb
    import mux_pkg::*;
#(
    parameter  int N_CH   = 4,
    parameter  int DATA_W = 8,
    localparam int SEL_W  = $clog2(N_CH)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [N_CH*DATA_W-1:0] in_data,
    input  logic [N_CH-1:0]        in_valid,
`ifdef MUX_RR_ARB_LOCK_EN
    input  logic [N_CH-1:0]        in_last,
`endif
    output logic [N_CH-1:0]        in_ready,
    input  logic                   mode,
    input  logic [SEL_W-1:0]       sel,
    output logic [DATA_W-1:0]      out_data,
    output logic [SEL_W-1:0]       out_sel,
    output logic                   out_valid,
    input  logic                   out_ready
);

    logic [DATA_W-1:0] out_data_q, out_data_d, gdata;
    logic [SEL_W-1:0]  out_sel_q, out_sel_d, ptr_q, ptr_d, gidx, nxt;
    logic              out_valid_q, out_valid_d, load, xfer, advance;
    logic [N_CH-1:0]   rr_grant, sel_grant, grant;

    rr_arbiter #(.N_CH(N_CH)) u_rr (
        .req_i   (in_valid),
        .ptr_i   (ptr_q),
        .grant_o (rr_grant)
    );

    assign load      = ~out_valid_q | out_ready;
    // An out-of-range sel shifts the bit off the top and yields no grant.
    assign sel_grant = in_valid & (N_CH'(1) << sel);

`ifdef MUX_RR_ARB_LOCK_EN
    logic             locked_q, locked_d, glast;
    logic [SEL_W-1:0] lock_ch_q, lock_ch_d;
    assign grant   = locked_q ? (in_valid & (N_CH'(1) << lock_ch_q))
                              : ((mode == MODE_SEL) ? sel_grant : rr_grant);
    assign advance = xfer & (mode == MODE_RR) & glast;
`else
    assign grant   = (mode == MODE_SEL) ? sel_grant : rr_grant;
    assign advance = xfer & (mode == MODE_RR);
`endif

    assign in_ready = load ? grant : '0;
    assign xfer     = load & (|grant);
    assign nxt      = (gidx == SEL_W'(N_CH - 1)) ? '0 : gidx + 1'b1;

    always_comb begin
        gidx  = '0;
        gdata = '0;
`ifdef MUX_RR_ARB_LOCK_EN
        glast = 1'b0;
`endif
        for (int i = 0; i < N_CH; i++) begin
            if (grant[i]) begin
                gidx  = SEL_W'(i);
                gdata = in_data[i*DATA_W +: DATA_W];
`ifdef MUX_RR_ARB_LOCK_EN
                glast = in_last[i];
`endif
            end
        end
    end

    always_comb begin
        out_valid_d = load ? xfer : out_valid_q;
        out_data_d  = xfer ? gdata : out_data_q;
        out_sel_d   = xfer ? gidx : out_sel_q;
        ptr_d       = advance ? nxt : ptr_q;
`ifdef MUX_RR_ARB_LOCK_EN
        locked_d    = xfer ? ~glast : locked_q;
        lock_ch_d   = xfer ? gidx : lock_ch_q;
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_sel_q   <= '0;
            ptr_q       <= '0;
`ifdef MUX_RR_ARB_LOCK_EN
            locked_q    <= 1'b0;
            lock_ch_q   <= '0;
`endif
        end else begin
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_sel_q   <= out_sel_d;
            ptr_q       <= ptr_d;
`ifdef MUX_RR_ARB_LOCK_EN
            locked_q    <= locked_d;
            lock_ch_q   <= lock_ch_d;
`endif
        end
    end

    assign out_data  = out_data_q;
    assign out_sel   = out_sel_q;
    assign out_valid = out_valid_q;

endmodule

// File: tb/tb_mux_rr_arb.sv
// tb_mux_rr_arb: directed and random checks of mux_rr_arb against a behavioural arbitration model.
module tb_mux_rr_arb;

    localparam int N = 4;
    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [N*W-1:0] in_data;
    logic [N-1:0] in_valid, in_ready, in_last;
    logic         mode, out_valid, out_ready;
    logic [1:0]   sel, out_sel;
    logic [W-1:0] out_data;

    logic [3*W-1:0] d3;
    logic [2:0]   v3, r3;
    logic         m3, ov3, or3;
    logic [1:0]   s3, os3;
    logic [W-1:0] od3;

    int n_chk = 0;
    int n_fail = 0;

    bit         mv, mlock;
    logic [7:0] md;
    int         ms, mptr, mlch;

    always #5 clk = ~clk;

    mux_rr_arb #(.N_CH(N), .DATA_W(W)) dut (
        .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid),
`ifdef MUX_RR_ARB_LOCK_EN
        .in_last(in_last),
`endif
        .in_ready(in_ready), .mode(mode), .sel(sel), .out_data(out_data),
        .out_sel(out_sel), .out_valid(out_valid), .out_ready(out_ready)
    );

    mux_rr_arb #(.N_CH(3), .DATA_W(W)) dut3 (
        .clk(clk), .rst_n(rst_n), .in_data(d3), .in_valid(v3),
`ifdef MUX_RR_ARB_LOCK_EN
        .in_last(3'b111),
`endif
        .in_ready(r3), .mode(m3), .sel(s3), .out_data(od3),
        .out_sel(os3), .out_valid(ov3), .out_ready(or3)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int pick();
        int idx;
        if (mv && !out_ready) return -1;
        if (mlock) return in_valid[mlch] ? mlch : -1;
        if (mode) return (int'(sel) < N && in_valid[sel]) ? int'(sel) : -1;
        for (int k = 0; k < N; k++) begin
            idx = (mptr + k) % N;
            if (in_valid[idx]) return idx;
        end
        return -1;
    endfunction

    task automatic cycle(input string tag);
        int g;
        bit last;
        #1;
        g = pick();
        chk({tag, "/in_ready"}, 32'(in_ready), (g < 0) ? 0 : (1 << g));
        if (!mv || out_ready) begin
            if (g >= 0) begin
                last = 1'b1;
`ifdef MUX_RR_ARB_LOCK_EN
                last = in_last[g];
                mlock = !last;
                mlch = g;
`endif
                mv = 1'b1;
                md = in_data[g*W +: W];
                ms = g;
                if (!mode && last) mptr = (g + 1) % N;
            end else mv = 1'b0;
        end
        @(posedge clk);
        #1;
        chk({tag, "/out_valid"}, 32'(out_valid), 32'(mv));
        chk({tag, "/out_data"}, 32'(out_data), 32'(md));
        chk({tag, "/out_sel"}, 32'(out_sel), ms);
    endtask

    task automatic model_reset();
        mv = 1'b0; md = '0; ms = 0; mptr = 0; mlock = 1'b0; mlch = 0;
    endtask

    initial begin
        in_data = '0; in_valid = '0; in_last = '1; mode = 1'b0; sel = '0; out_ready = 1'b1;
        d3 = {8'h33, 8'h22, 8'h11}; v3 = '0; m3 = 1'b1; s3 = '0; or3 = 1'b1;
        model_reset();
        @(posedge clk); @(posedge clk); #1;
        chk("reset/out_valid", 32'(out_valid), 0);
        chk("reset/out_data", 32'(out_data), 0);
        chk("reset/out_sel", 32'(out_sel), 0);
        rst_n = 1'b1;

        in_data = {8'hD3, 8'hC2, 8'hB1, 8'hA0};
        in_valid = 4'b1111;
        for (int i = 0; i < 5; i++) begin
            cycle("rr");
            chk("rr/seq", 32'(out_sel), i % 4);
            chk("rr/seq_data", 32'(out_data), 32'(8'hA0 + 8'h11 * (i % 4)));
        end

        in_valid = 4'b0100;
        in_data = {8'hD3, 8'hA5, 8'hB1, 8'hA0};
        cycle("bp_load");
        chk("bp/a5_loaded", 32'(out_data), 32'h A5);
        out_ready = 1'b0;
        in_valid = 4'b1111;
        for (int i = 0; i < 3; i++) begin
            cycle("bp_stall");
            chk("bp/a5_held", 32'(out_data), 32'h A5);
            chk("bp/rdy_zero", 32'(in_ready), 0);
        end
        out_ready = 1'b1;
        cycle("bp_release");
        chk("bp/next_ch3", 32'(out_sel), 3);

        mode = 1'b1; sel = 2'd1;
        cycle("sel1_a");
        cycle("sel1_b");
        chk("sel/ch1", 32'(out_sel), 1);
        mode = 1'b0;
        cycle("sel_ptr_hold");
        chk("sel/ptr_unchanged", 32'(out_sel), 0);

        in_valid = 4'b1001;
        cycle("wrap_a");
        chk("wrap/ch3", 32'(out_sel), 3);
        cycle("wrap_b");
        chk("wrap/ch0", 32'(out_sel), 0);
        in_valid = 4'b0000;
        cycle("drain");
        chk("drain/valid_low", 32'(out_valid), 0);

`ifdef MUX_RR_ARB_LOCK_EN
        in_valid = 4'b0111;
        in_last = 4'b1111; in_last[1] = 1'b0;
        cycle("lock_b0");
        cycle("lock_b1");
        in_last[1] = 1'b1;
        cycle("lock_b2");
        chk("lock/three_beats_ch1", 32'(out_sel), 1);
        cycle("lock_after");
        chk("lock/then_ch2", 32'(out_sel), 2);
        in_last = '1;
`endif

        in_valid = 4'b1111;
        cycle("pre_reset");
        rst_n = 1'b0;
        #1;
        chk("async_rst/out_valid", 32'(out_valid), 0);
        chk("async_rst/out_data", 32'(out_data), 0);
        chk("async_rst/ptr", 32'(dut.ptr_q), 0);
        model_reset();
        @(posedge clk); #1;
        rst_n = 1'b1;

        for (int i = 0; i < 400; i++) begin
            in_valid = 4'($urandom);
            in_data = $urandom;
            mode = ($urandom % 4) == 0;
            sel = 2'($urandom);
            out_ready = ($urandom % 4) != 0;
`ifdef MUX_RR_ARB_LOCK_EN
            in_last = 4'($urandom);
`endif
            cycle("rand");
        end

        v3 = 3'b111; s3 = 2'd0;
        @(posedge clk); #1;
        chk("n3/load_valid", 32'(ov3), 1);
        chk("n3/load_sel", 32'(os3), 0);
        s3 = 2'd3;
        #1;
        chk("n3/oor_ready", 32'(r3), 0);
        @(posedge clk); #1;
        chk("n3/oor_drain", 32'(ov3), 0);
        chk("n3/oor_data_hold", 32'(od3), 32'h11);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
